// File: rtl/irq_prio_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : irq_prio_arbiter
// Purpose  : Latches, masks and fixed-priority arbitrates peripheral IRQs for
//            the RV32 trap logic; tracks one in-service interrupt until MRET.
//            Optional IRQ_LATENCY_CNT_EN adds a request-to-ack latency counter.
// Revision : 1.0 - initial release
// ============================================================================
module irq_prio_arbiter #(
    parameter int NUM_IRQ  = 8,
    parameter int IRQ_BASE = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic [1:0]         reg_addr,
    input  logic [15:0]        reg_wdata,
    input  logic               reg_wen,
    output logic [15:0]        reg_rdata,
    output logic               irq_req,
    output logic [4:0]         irq_id,
    input  logic               irq_ack,
    input  logic               irq_done
);

    localparam logic [1:0] c_ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] c_ADDR_PENDING = 2'd1;
    localparam logic [1:0] c_ADDR_EDGE    = 2'd2;
    localparam logic [1:0] c_ADDR_STATUS  = 2'd3;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_REQ     = 2'd1;
    localparam logic [1:0] c_ST_SERVICE = 2'd2;

    localparam logic [4:0] c_IRQ_BASE = IRQ_BASE[4:0];

    logic [NUM_IRQ-1:0] r_enable;
    logic [NUM_IRQ-1:0] r_edge;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_src_d;
    logic [NUM_IRQ-1:0] r_req_oh;
    logic [1:0]         r_state;
    logic               r_irq_req;
    logic [4:0]         r_irq_id;
    logic [4:0]         r_act_id;

    logic [NUM_IRQ-1:0] w_cand;
    logic [NUM_IRQ-1:0] w_win_oh;
    logic [3:0]         w_win_idx;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_w1c;
    logic [NUM_IRQ-1:0] w_pending_nxt;
    logic [15:0]        w_status;
    logic               w_unused;

    assign w_cand   = r_pending & r_enable;
    assign w_win_oh = w_cand & (~w_cand + NUM_IRQ'(1));
    assign w_rise   = irq_src & ~r_src_d;
    assign w_w1c    = (reg_wen && reg_addr == c_ADDR_PENDING) ? reg_wdata[NUM_IRQ-1:0] : '0;
    // A fresh edge overrides a simultaneous W1C; level bits just follow the source.
    assign w_pending_nxt = (r_edge & ((r_pending & ~w_w1c) | w_rise)) | (~r_edge & irq_src);
    assign w_status = {r_state == c_ST_SERVICE, r_irq_req, 9'b0, r_act_id};
    assign w_unused = ^reg_wdata;

    always_comb begin
        w_win_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_cand[i]) w_win_idx = 4'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable  <= '0;
            r_edge    <= '0;
            r_pending <= '0;
            r_src_d   <= '0;
            r_req_oh  <= '0;
            r_state   <= c_ST_IDLE;
            r_irq_req <= 1'b0;
            r_irq_id  <= '0;
            r_act_id  <= '0;
        end else begin
            r_src_d   <= irq_src;
            r_pending <= w_pending_nxt;
            if (reg_wen && reg_addr == c_ADDR_ENABLE) r_enable <= reg_wdata[NUM_IRQ-1:0];
            if (reg_wen && reg_addr == c_ADDR_EDGE)   r_edge   <= reg_wdata[NUM_IRQ-1:0];
            case (r_state)
                c_ST_IDLE: begin
                    if (|w_cand) begin
                        r_state   <= c_ST_REQ;
                        r_irq_req <= 1'b1;
                        r_irq_id  <= c_IRQ_BASE + {1'b0, w_win_idx};
                        r_req_oh  <= w_win_oh;
                    end
                end
                c_ST_REQ: begin
                    // The ack takes precedence over a winner that is withdrawn in the same cycle.
                    if (irq_ack) begin
                        r_state   <= c_ST_SERVICE;
                        r_irq_req <= 1'b0;
                        r_act_id  <= r_irq_id;
                    end else if (!(|(w_cand & r_req_oh))) begin
                        r_state   <= c_ST_IDLE;
                        r_irq_req <= 1'b0;
                    end
                end
                c_ST_SERVICE: begin
                    if (irq_done) begin
                        r_state  <= c_ST_IDLE;
                        r_act_id <= '0;
                    end
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_irq_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef IRQ_LATENCY_CNT_EN
    logic [15:0] r_lat_cnt;
    logic        r_lat_view;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lat_cnt  <= '0;
            r_lat_view <= 1'b0;
        end else begin
            if (r_state == c_ST_IDLE && |w_cand) begin
                r_lat_cnt <= '0;
            end else if (r_state == c_ST_REQ && !irq_ack && r_lat_cnt != 16'hFFFF) begin
                r_lat_cnt <= r_lat_cnt + 16'd1;
            end
            if (reg_wen && reg_addr == c_ADDR_STATUS) r_lat_view <= reg_wdata[0];
        end
    end
`endif

    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            c_ADDR_ENABLE:  reg_rdata = 16'(r_enable);
            c_ADDR_PENDING: reg_rdata = 16'(r_pending);
            c_ADDR_EDGE:    reg_rdata = 16'(r_edge);
            default: begin
`ifdef IRQ_LATENCY_CNT_EN
                reg_rdata = r_lat_view ? r_lat_cnt : w_status;
`else
                reg_rdata = w_status;
`endif
            end
        endcase
    end

    assign irq_req = r_irq_req;
    assign irq_id  = r_irq_id;

endmodule
`default_nettype wire

// File: tb/tb_irq_prio_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_prio_arbiter
// Purpose  : Directed and random stimulus for irq_prio_arbiter, checked every
//            cycle against an array-based reference model of the controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_prio_arbiter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] irq_src = '0;
    logic [1:0]   reg_addr = '0;
    logic [15:0]  reg_wdata = '0;
    logic         reg_wen = 1'b0;
    logic [15:0]  reg_rdata;
    logic         irq_req;
    logic [4:0]   irq_id;
    logic         irq_ack = 1'b0;
    logic         irq_done = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: 0 idle, 1 requesting, 2 in service
    bit [15:0] m_enable, m_edge, m_pending, m_src_d;
    int        m_state, m_win, m_id, m_act, m_lat;
    bit        m_req, m_view;

    irq_prio_arbiter #(.NUM_IRQ(N), .IRQ_BASE(16)) dut (
        .clk(clk), .rst(rst), .irq_src(irq_src), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_wen(reg_wen), .reg_rdata(reg_rdata),
        .irq_req(irq_req), .irq_id(irq_id), .irq_ack(irq_ack), .irq_done(irq_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [1:0] a);
        logic [15:0] st;
        case (a)
            2'd0: return m_enable;
            2'd1: return m_pending;
            2'd2: return m_edge;
            default: begin
                st = 16'(m_act & 31);
                if (m_state == 2) st[15] = 1'b1;
                if (m_req) st[14] = 1'b1;
`ifdef IRQ_LATENCY_CNT_EN
                if (m_view) st = 16'(m_lat);
`endif
                return st;
            end
        endcase
    endfunction

    task automatic model_step();
        bit [15:0] cand, p_new;
        int win;
        if (rst) begin
            m_enable = 0; m_edge = 0; m_pending = 0; m_src_d = 0;
            m_state = 0; m_win = 0; m_id = 0; m_act = 0; m_lat = 0;
            m_req = 0; m_view = 0;
            return;
        end
        cand = m_pending & m_enable;
        win = -1;
        for (int i = N - 1; i >= 0; i--) if (cand[i]) win = i;
        p_new = 0;
        for (int i = 0; i < N; i++) begin
            if (m_edge[i]) begin
                p_new[i] = m_pending[i];
                if (reg_wen && reg_addr == 2'd1 && reg_wdata[i]) p_new[i] = 1'b0;
                if (irq_src[i] && !m_src_d[i]) p_new[i] = 1'b1;
            end else begin
                p_new[i] = irq_src[i];
            end
        end
        if (m_state == 0) begin
            if (win >= 0) begin
                m_state = 1; m_req = 1; m_id = 16 + win; m_win = win; m_lat = 0;
            end
        end else if (m_state == 1) begin
            if (!irq_ack && m_lat < 65535) m_lat++;
            if (irq_ack) begin
                m_state = 2; m_req = 0; m_act = m_id;
            end else if (!(m_pending[m_win] && m_enable[m_win])) begin
                m_state = 0; m_req = 0;
            end
        end else if (irq_done) begin
            m_state = 0; m_act = 0;
        end
        if (reg_wen && reg_addr == 2'd0) m_enable = reg_wdata & 16'h00FF;
        if (reg_wen && reg_addr == 2'd2) m_edge   = reg_wdata & 16'h00FF;
        if (reg_wen && reg_addr == 2'd3) m_view   = reg_wdata[0];
        m_pending = p_new;
        m_src_d   = 16'(irq_src);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_req", 16'(irq_req), 16'(m_req));
        if (m_req) check("model_id", 16'(irq_id), 16'(m_id));
        check("model_rdata", reg_rdata, m_read(reg_addr));
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [15:0] d);
        reg_addr = a; reg_wdata = d; reg_wen = 1'b1;
        tick();
        reg_wen = 1'b0; reg_wdata = '0;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [15:0] exp);
        reg_addr = a;
        #1;
        check(tag, reg_rdata, exp);
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    endtask

    task automatic pulse_done();
        irq_done = 1'b1; tick(); irq_done = 1'b0;
    endtask

    task automatic wait_req(input int budget);
        for (int k = 0; k < budget && !irq_req; k++) tick();
        check("wait_req_timeout", 16'(irq_req), 16'd1);
    endtask

    initial begin
        // Reset state
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        check_reg("rst_enable", 2'd0, 16'h0000);
        check_reg("rst_pending", 2'd1, 16'h0000);
        check_reg("rst_edge", 2'd2, 16'h0000);
        check_reg("rst_status", 2'd3, 16'h0000);
        check("rst_req", 16'(irq_req), 16'd0);
        check("rst_id", 16'(irq_id), 16'd0);

        // Single edge source, serviced twice
        reg_write(2'd2, 16'h0002);
        reg_write(2'd0, 16'h0002);
        for (int rep = 0; rep < 2; rep++) begin
            irq_src = 8'h02; tick(); irq_src = 8'h00;
            check_reg("t1_pending", 2'd1, 16'h0002);
            check("t1_req_early", 16'(irq_req), 16'd0);
            tick();
            check("t1_req", 16'(irq_req), 16'd1);
            check("t1_id", 16'(irq_id), 16'd17);
            pulse_ack();
            check_reg("t2_status_svc", 2'd3, 16'h8011);
            reg_write(2'd1, 16'h0002);
            check_reg("t2_pending_clr", 2'd1, 16'h0000);
            pulse_done();
            check_reg("t2_status_idle", 2'd3, 16'h0000);
            check("t2_req_idle", 16'(irq_req), 16'd0);
        end

        // Two simultaneous edges: priority order and the one-cycle gap
        reg_write(2'd2, 16'h0006);
        reg_write(2'd0, 16'h0006);
        irq_src = 8'h06; tick(); irq_src = 8'h00; tick();
        check("t3_first_id", 16'(irq_id), 16'd17);
        pulse_ack();
        reg_write(2'd1, 16'h0002);
        pulse_done();
        check("t3_gap", 16'(irq_req), 16'd0);
        tick();
        check("t3_second_req", 16'(irq_req), 16'd1);
        check("t3_second_id", 16'(irq_id), 16'd18);
        pulse_ack();
        reg_write(2'd1, 16'h0004);
        pulse_done();

        // Level source withdrawn by disabling it before the ack
        reg_write(2'd2, 16'h0000);
        reg_write(2'd0, 16'h0008);
        irq_src = 8'h08; tick(); tick();
        check("t4_req", 16'(irq_req), 16'd1);
        check("t4_id", 16'(irq_id), 16'd19);
        reg_write(2'd0, 16'h0000);
        tick();
        check("t4_drop", 16'(irq_req), 16'd0);
        pulse_ack();
        check_reg("t4_ack_ignored", 2'd3, 16'h0000);
        irq_src = 8'h00; tick();

        // Reset while in service with two pending bits
        reg_write(2'd2, 16'h0006);
        reg_write(2'd0, 16'h0006);
        irq_src = 8'h06; tick(); irq_src = 8'h00; tick();
        pulse_ack();
        check_reg("t5_pending", 2'd1, 16'h0006);
        rst = 1'b1; tick(); rst = 1'b0;
        check_reg("t5_enable", 2'd0, 16'h0000);
        check_reg("t5_pending_rst", 2'd1, 16'h0000);
        check_reg("t5_edge", 2'd2, 16'h0000);
        check_reg("t5_status", 2'd3, 16'h0000);
        check("t5_req", 16'(irq_req), 16'd0);

        // Ack five cycles after the request rises, then read the STATUS/latency view
        reg_write(2'd2, 16'h0002);
        reg_write(2'd0, 16'h0002);
        irq_src = 8'h02; tick(); irq_src = 8'h00;
        wait_req(4);
        for (int k = 0; k < 5; k++) tick();
        pulse_ack();
        reg_write(2'd3, 16'h0001);
`ifdef IRQ_LATENCY_CNT_EN
        check_reg("t6_latency", 2'd3, 16'h0005);
`else
        check_reg("t6_status_view", 2'd3, 16'h8011);
`endif
        reg_write(2'd3, 16'h0000);
        check_reg("t6_status_back", 2'd3, 16'h8011);
        reg_write(2'd1, 16'h0002);
        pulse_done();

        // Random traffic against the reference model
        reg_write(2'd2, 16'h0055);
        reg_write(2'd0, 16'h00FF);
        for (int c = 0; c < 3000; c++) begin
            irq_src   = N'($urandom);
            rst       = ($urandom_range(0, 299) == 0);
            irq_ack   = ($urandom_range(0, 3) == 0);
            irq_done  = ($urandom_range(0, 5) == 0);
            reg_wen   = ($urandom_range(0, 7) == 0);
            reg_addr  = 2'($urandom);
            reg_wdata = 16'($urandom);
            tick();
        end
        rst = 1'b0; irq_ack = 1'b0; irq_done = 1'b0; reg_wen = 1'b0; irq_src = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
